// File: rtl/mul_seq_pkg.sv
// Shared state encoding and control strobe bundle for the sequential shift-add multiplier.
// The FIX encoding is only reachable when MUL_SEQ_SIGNED_MODE_EN is defined.
package mul_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // One-hot-ish strobes from the controller to the datapath.
    typedef struct packed {
        logic load;
        logic step;
        logic last;
        logic fix;
    } strobe_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle of mul_seq: operands and start in, product and status out.
// signed_mode exists only when MUL_SEQ_SIGNED_MODE_EN is defined.
interface mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     word1;
    logic [WIDTH-1:0]     word2;
`ifdef MUL_SEQ_SIGNED_MODE_EN
    logic                 signed_mode;
`endif
    logic [2*WIDTH-1:0]   product;
    logic                 ready;
    logic                 busy;
    logic                 done;

    modport master (
        output start, word1, word2,
`ifdef MUL_SEQ_SIGNED_MODE_EN
        output signed_mode,
`endif
        input  product, ready, busy, done
    );

    modport slave (
        input  start, word1, word2,
`ifdef MUL_SEQ_SIGNED_MODE_EN
        input  signed_mode,
`endif
        output product, ready, busy, done
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencing FSM and iteration down-counter for mul_seq; emits datapath strobes and status.
// The FIX state and fix_req_i port exist only with MUL_SEQ_SIGNED_MODE_EN.
//
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   CALC  | one add-and-shift per cycle, counter WIDTH..1
//   FIX   | apply sign to magnitude product (signed mode only)
//   DONE  | product just updated, done=1 for one cycle
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    start_i,
`ifdef MUL_SEQ_SIGNED_MODE_EN
    input  logic    fix_req_i,
`endif
    output strobe_t strb_o,
    output logic    ready_o,
    output logic    busy_o,
    output logic    done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last;
    logic               fix_req;

`ifdef MUL_SEQ_SIGNED_MODE_EN
    assign fix_req = fix_req_i;
`else
    assign fix_req = 1'b0;
`endif

    assign last = (state_q == ST_CALC) && (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = fix_req ? ST_FIX : ST_DONE;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign strb_o.load = (state_q == ST_IDLE) && start_i;
    assign strb_o.step = (state_q == ST_CALC);
    assign strb_o.last = last;
    assign strb_o.fix  = (state_q == ST_FIX);

    // Status is forced low while reset is held so the caller never sees a stale ready.
    assign ready_o = (state_q == ST_IDLE) && reset;
    assign busy_o  = (state_q != ST_IDLE) && reset;
    assign done_o  = (state_q == ST_DONE);

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: WIDTH iterations, registered product, one-cycle done pulse.
// Define MUL_SEQ_SIGNED_MODE_EN to add two's-complement operands via signed_mode.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    mul_seq_if.slave bus
);

    localparam int AW = 2 * WIDTH + 1;

    strobe_t              strb;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       upper_sum;
    logic [AW-1:0]        acc_add;
    logic [AW-1:0]        acc_shift;
    logic [WIDTH-1:0]     op1, op2;

`ifdef MUL_SEQ_SIGNED_MODE_EN
    logic sgn_q, sgn_d;
    logic neg_q, neg_d;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
    assign op1 = (bus.signed_mode && bus.word1[WIDTH-1]) ? -bus.word1 : bus.word1;
    assign op2 = (bus.signed_mode && bus.word2[WIDTH-1]) ? -bus.word2 : bus.word2;
`else
    assign op1 = bus.word1;
    assign op2 = bus.word2;
`endif

    mul_seq_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start_i   (bus.start),
`ifdef MUL_SEQ_SIGNED_MODE_EN
        .fix_req_i (sgn_q),
`endif
        .strb_o    (strb),
        .ready_o   (bus.ready),
        .busy_o    (bus.busy),
        .done_o    (bus.done)
    );

    // Upper half keeps its carry in the extra MSB, which the shift then brings down.
    assign upper_sum = acc_q[AW-1:WIDTH] + {1'b0, mcand_q};
    assign acc_add   = acc_q[0] ? {upper_sum, acc_q[WIDTH-1:0]} : acc_q;
    assign acc_shift = acc_add >> 1;

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
`ifdef MUL_SEQ_SIGNED_MODE_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
`endif
        if (strb.load) begin
            mcand_d = op1;
            acc_d   = {{(WIDTH+1){1'b0}}, op2};
`ifdef MUL_SEQ_SIGNED_MODE_EN
            sgn_d   = bus.signed_mode;
            neg_d   = bus.signed_mode && (bus.word1[WIDTH-1] ^ bus.word2[WIDTH-1]);
`endif
        end else if (strb.step) begin
            acc_d = acc_shift;
        end

`ifdef MUL_SEQ_SIGNED_MODE_EN
        if (strb.last && !sgn_q) begin
            prod_d = acc_shift[2*WIDTH-1:0];
        end
        if (strb.fix) begin
            prod_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        end
`else
        if (strb.last) begin
            prod_d = acc_shift[2*WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
`ifdef MUL_SEQ_SIGNED_MODE_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
`ifdef MUL_SEQ_SIGNED_MODE_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign bus.product = prod_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq at WIDTH=8 and WIDTH=4; signed vectors run when
// MUL_SEQ_SIGNED_MODE_EN is defined.
module tb_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mul_seq_if #(.WIDTH(8)) if8 ();
    mul_seq_if #(.WIDTH(4)) if4 ();

    mul_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst), .bus(if8));
    mul_seq #(.WIDTH(4)) dut4 (.clk(clk), .reset(rst), .bus(if4));

    logic [15:0] exp8[$];
    int          due8[$];
    logic [7:0]  exp4[$];
    int          due4[$];
    logic [15:0] held8 = '0;
    logic [7:0]  held4 = '0;
    int          done8 = 0;
    int          done4 = 0;
`ifdef MUL_SEQ_SIGNED_MODE_EN
    logic        sm8 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Monitors sample 3 time units after the active edge.
    always @(posedge clk) begin
        logic [15:0] e;
        int d;
        #3;
        if (!rst) begin
            chk("rst_product8", if8.product, 0);
            chk("rst_done8", if8.done, 0);
            chk("rst_ready8", if8.ready, 0);
            chk("rst_busy8", if8.busy, 0);
            held8 = '0;
        end else if (if8.done) begin
            done8++;
            if (exp8.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done8: product %0d with nothing pending at cycle %0d", if8.product, cyc);
            end else begin
                e = exp8.pop_front();
                d = due8.pop_front();
                chk("product8", if8.product, e);
                chk("latency8", cyc, d);
            end
            held8 = if8.product;
        end else begin
            chk("hold8", if8.product, held8);
        end
    end

    always @(posedge clk) begin
        logic [7:0] e;
        int d;
        #3;
        if (!rst) begin
            chk("rst_product4", if4.product, 0);
            chk("rst_ready4", if4.ready, 0);
            held4 = '0;
        end else if (if4.done) begin
            done4++;
            if (exp4.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done4: product %0d with nothing pending at cycle %0d", if4.product, cyc);
            end else begin
                e = exp4.pop_front();
                d = due4.pop_front();
                chk("product4", if4.product, e);
                chk("latency4", cyc, d);
            end
            held4 = if4.product;
        end else begin
            chk("hold4", if4.product, held4);
        end
    end

    // lat: cycles from the negedge that presents start to the cycle showing done.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e,
                          input int lat, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (!if8.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_bound("ready8_wait");
        if8.start = 1'b1;
        if8.word1 = a;
        if8.word2 = b;
`ifdef MUL_SEQ_SIGNED_MODE_EN
        if8.signed_mode = sm8;
`endif
        if (track) begin
            exp8.push_back(e);
            due8.push_back(cyc + lat);
        end
        @(negedge clk);
        if8.start = 1'b0;
        if8.word1 = 8'hA5;
        if8.word2 = 8'h5A;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!if4.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_bound("ready4_wait");
        if4.start = 1'b1;
        if4.word1 = a;
        if4.word2 = b;
        exp4.push_back(e);
        due4.push_back(cyc + 5);
        @(negedge clk);
        if4.start = 1'b0;
        if4.word1 = 4'h6;
        if4.word2 = 4'h9;
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while ((exp8.size() != 0 || !if8.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_bound("idle8_wait");
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while ((exp4.size() != 0 || !if4.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_bound("idle4_wait");
    endtask

    logic [7:0]  b2b_a [4] = '{8'd7,  8'd100, 8'd17,  8'd200};
    logic [7:0]  b2b_b [4] = '{8'd9,  8'd3,   8'd15,  8'd200};
    logic [15:0] b2b_p [4] = '{16'd63, 16'd300, 16'd255, 16'd40000};

    initial begin
        int n;
        int prev;
        int d0;
        if8.start = 1'b0; if8.word1 = '0; if8.word2 = '0;
        if4.start = 1'b0; if4.word1 = '0; if4.word2 = '0;
`ifdef MUL_SEQ_SIGNED_MODE_EN
        if8.signed_mode = 1'b0;
        if4.signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // First operation: done latency and ready one cycle later.
        issue8(8'd13, 8'd11, 16'd143, 9, 1'b1);
        n = 0;
        while (!if8.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) fail_bound("done8_wait");
        chk("ready_during_done", if8.ready, 0);
        @(negedge clk);
        chk("ready_after_done", if8.ready, 1);

        issue8(8'd255, 8'd255, 16'd65025, 9, 1'b1);
        issue8(8'd0,   8'd200, 16'd0,     9, 1'b1);
        issue8(8'hFD,  8'd5,   16'd1265,  9, 1'b1);
        issue8(8'd128, 8'd2,   16'd256,   9, 1'b1);
        wait_idle8();

        // start held high with operands changing while busy.
        d0 = done8;
        prev = 0;
        if8.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!if8.ready && n < 30) begin
                if8.word1 = 8'($urandom);
                if8.word2 = 8'($urandom);
                @(negedge clk);
                n++;
            end
            if (n >= 30) fail_bound("b2b_ready_wait");
            if8.word1 = b2b_a[k];
            if8.word2 = b2b_b[k];
            exp8.push_back(b2b_p[k]);
            due8.push_back(cyc + 9);
            if (k > 0) chk("b2b_period", cyc - prev, 10);
            prev = cyc;
            @(negedge clk);
        end
        if8.start = 1'b0;
        wait_idle8();
        chk("b2b_done_count", done8 - d0, 4);

        // Reset pulse in the middle of CALC aborts without done.
        d0 = done8;
        issue8(8'd77, 8'd3, 16'd231, 9, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_in_reset", if8.ready, 0);
        chk("busy_in_reset", if8.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_product", if8.product, 0);
        chk("ready_after_reset", if8.ready, 1);
        repeat (15) @(negedge clk);
        chk("abort_no_done", done8 - d0, 0);

        issue4(4'd15,    4'd15,    8'd225);
        issue4(4'b1010,  4'b0101,  8'd50);
        issue4(4'd0,     4'd9,     8'd0);
        issue4(4'd3,     4'd7,     8'd21);
        wait_idle4();

`ifdef MUL_SEQ_SIGNED_MODE_EN
        sm8 = 1'b1;
        issue8(8'hFD, 8'd5,  16'hFFF1,  10, 1'b1);
        issue8(8'h80, 8'h80, 16'd16384, 10, 1'b1);
        issue8(8'd7,  8'hFE, 16'hFFF2,  10, 1'b1);
        sm8 = 1'b0;
        issue8(8'hFD, 8'd5,  16'd1265,  9,  1'b1);
        wait_idle8();
`endif

        chk("queue8_drained", exp8.size(), 0);
        chk("queue4_drained", exp4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
